// File: rtl/pb2_ail_pkg.sv
// Shared constants for the Processor Board B autoindex detector.
// These are the instruction field positions and the page-zero autoindex window.
package pb2_ail_pkg;
  localparam int IBUS_W      = 16;
  localparam int I_BIT       = 11;
  localparam int R_BIT       = 10;
  localparam int OPERAND_MSB = 9;
  localparam logic [OPERAND_MSB:0] AINDEX_LO = 10'h080;
  localparam logic [OPERAND_MSB:0] AINDEX_HI = 10'h0FF;
endpackage

// File: rtl/pb2_ail_decode.sv
// Combinational autoindex decode: indirect, register page, operand in the window.
// The opcode field and operand bits [6:0] do not change the result.
module pb2_ail_decode
  import pb2_ail_pkg::*;
(
  input  logic [IBUS_W-1:0] ibus,
  output logic              hit
);

  logic [OPERAND_MSB:0] operand;
  logic                 unused_opcode;

  assign operand       = ibus[OPERAND_MSB:0];
  assign unused_opcode = ^ibus[IBUS_W-1:I_BIT+1];

  assign hit = ibus[I_BIT] & ibus[R_BIT]
             & (operand >= AINDEX_LO) & (operand <= AINDEX_HI);

endmodule

// File: rtl/pb2_ail.sv
// Autoindex flag register: captures the decode of each IR write.
// The active-low flag comes straight from a flop so it is glitch-free downstream.
module pb2_ail
  import pb2_ail_pkg::*;
(
  input  logic              clk,
  input  logic              nreset,
  input  logic [IBUS_W-1:0] ibus,
  input  logic              nwir,
  output logic              naindex
);

  logic hit;

  pb2_ail_decode u_decode (
    .ibus (ibus),
    .hit  (hit)
  );

  always_ff @(posedge clk) begin
    if (!nreset) begin
      naindex <= 1'b1;
    end else if (!nwir) begin
      naindex <= ~hit;
    end
  end

endmodule

// File: tb/tb_pb2_ail.sv
// Randomized and directed bench for pb2_ail against an arithmetic reference model.
module tb_pb2_ail;

  logic        clk = 1'b0;
  logic        nreset;
  logic [15:0] ibus;
  logic        nwir;
  logic        naindex;

  int checks = 0;
  int errors = 0;
  logic model_q;

  pb2_ail dut (
    .clk     (clk),
    .nreset  (nreset),
    .ibus    (ibus),
    .nwir    (nwir),
    .naindex (naindex)
  );

  always #5 clk = ~clk;

  function automatic logic ref_naindex(input logic [15:0] word);
    int unsigned operand;
    operand = int'(word) % 1024;
    if (word[11] == 1'b1 && word[10] == 1'b1 && operand >= 128 && operand <= 255)
      return 1'b0;
    return 1'b1;
  endfunction

  task automatic check_val(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s naindex=%b expected=%b", tag, got, exp);
    end
  endtask

  // Apply one clock with the given inputs, advance the model, sample 1ns after the edge.
  task automatic step(input logic nr, input logic nw, input logic [15:0] word);
    nreset = nr;
    nwir   = nw;
    ibus   = word;
    @(posedge clk);
    if (!nr)      model_q = 1'b1;
    else if (!nw) model_q = ref_naindex(word);
    #1;
  endtask

  task automatic load(input string tag, input logic [15:0] word, input logic exp);
    step(1'b1, 1'b0, word);
    check_val(tag, naindex, exp);
    check_val({tag, "_model"}, naindex, model_q);
    step(1'b1, 1'b1, $urandom());
  endtask

  initial begin
    logic [15:0] w;
    model_q = 1'b1;
    nreset = 1'b0;
    nwir   = 1'b1;
    ibus   = 16'h0000;
    #2;

    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0C80);
    check_val("reset", naindex, 1'b1);
    step(1'b1, 1'b0, 16'h0C80);
    check_val("after_reset", naindex, 1'b0);
    step(1'b1, 1'b1, 16'h0000);

    load("op_07f", 16'h0C7F, 1'b1);
    load("op_080", 16'h0C80, 1'b0);
    load("op_0ff", 16'h0CFF, 1'b0);
    load("op_100", 16'h0D00, 1'b1);
    load("op_3ff", 16'h0FFF, 1'b1);
    load("opcode_ff", 16'hFC80, 1'b0);
    load("mix_3cc5", 16'h3CC5, 1'b0);
    load("r_zero", 16'h0880, 1'b1);
    load("i_zero", 16'h0480, 1'b1);
    load("ir_zero", 16'h0080, 1'b1);

    load("hold_load", 16'h0C90, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, 16'h0000);
      check_val("hold", naindex, 1'b0);
    end

    step(1'b1, 1'b0, 16'h0C80);
    check_val("strobe_first", naindex, 1'b0);
    step(1'b1, 1'b0, 16'h0000);
    check_val("strobe_last", naindex, 1'b1);
    step(1'b1, 1'b1, 16'h0C80);
    check_val("strobe_end", naindex, 1'b1);

    load("pre_rst", 16'h0CA0, 1'b0);
    step(1'b0, 1'b0, 16'h0CA0);
    check_val("rst_over_wir", naindex, 1'b1);
    step(1'b1, 1'b1, 16'h0CA0);
    check_val("rst_release_idle", naindex, 1'b1);

    // Every decode-relevant pattern of [11:0], random opcode, strobe held low.
    for (int v = 0; v < 4096; v++) begin
      w = {4'($urandom()), 12'(v)};
      step(1'b1, 1'b0, w);
      check_val("sweep", naindex, ref_naindex(w));
    end

    // Random mix of resets, strobes and bus traffic, biased toward the window.
    for (int i = 0; i < 3000; i++) begin
      w = $urandom();
      if ($urandom_range(0, 3) == 0) w[11:7] = 5'b11001;
      step(($urandom_range(0, 19) != 0), $urandom_range(0, 1) == 1, w);
      check_val("random", naindex, model_q);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
